// File: rtl/apb_pkg.sv
// Shared definitions for the CPU-to-APB bridge: bus widths, FSM states and
// the peripheral address map behind the APB decode mux.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERR
    } apb_state_e;

    localparam logic [31:0] DMEM_BASE   = 32'h0000_3000;
    localparam logic [31:0] DMEM_LAST   = 32'h0000_37FF;
    localparam logic [31:0] SWITCH_ADDR = 32'h0000_0020;
    localparam logic [31:0] LED_ADDR    = 32'h0000_0024;
    localparam logic [31:0] TIMER_BASE  = 32'h0000_0000;
    localparam logic [31:0] TIMER_LAST  = 32'h0000_0018;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// CPU request/response channel plus APB master signals of the bridge.
// The master modport is the bridge's view; slave is the CPU + APB fabric view.
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] M_PADDR;
    logic              M_PWRITE;
    logic              M_PSEL;
    logic              M_PENABLE;
    logic [DATA_W-1:0] M_PWDATA;
    logic [DATA_W-1:0] M_PRDATA;
    logic              M_PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  M_PRDATA, M_PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output M_PADDR, M_PWRITE, M_PSEL, M_PENABLE, M_PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output M_PRDATA, M_PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  M_PADDR, M_PWRITE, M_PSEL, M_PENABLE, M_PWDATA
    );

endinterface

// File: rtl/apb_master_bridge.sv
// Single-beat CPU load/store to APB3 bridge with wait states, bounded-wait
// timeout, misaligned-address rejection and back-to-back SETUP chaining.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_master_bridge_if.master bus
);

    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    apb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic timeout_hit;
    logic complete;
    logic req_ready;
    logic accept;

    // A forced timeout only applies when PREADY is low; PREADY on the same edge wins.
    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST) && !bus.M_PREADY;
        complete    = (state_q == ACCESS) && (bus.M_PREADY || timeout_hit);
        req_ready   = (state_q == IDLE) || complete;
        accept      = bus.req_valid && req_ready;
    end

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        unique case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                if (complete) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !bus.M_PREADY;
                    rsp_rdata_d = (bus.M_PREADY && !pwrite_q) ? bus.M_PRDATA : '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Acceptance overrides the IDLE/ACCESS-completion defaults above so a
        // chained aligned request keeps PSEL high straight into SETUP.
        if (accept) begin
            if (is_word_aligned(bus.req_addr[1:0])) begin
                state_d   = SETUP;
                psel_d    = 1'b1;
                penable_d = 1'b0;
                paddr_d   = bus.req_addr;
                pwrite_d  = bus.req_write;
                pwdata_d  = bus.req_wdata;
            end else begin
                state_d   = ERR;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.M_PADDR   = paddr_q;
    assign bus.M_PWRITE  = pwrite_q;
    assign bus.M_PWDATA  = pwdata_q;
    assign bus.M_PSEL    = psel_q;
    assign bus.M_PENABLE = penable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: APB slave model with per-transfer
// wait states, and a transaction-level reference predicting each response.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int unsigned T = 4;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cycle;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } setup_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    rsp_t   rsp_q[$];
    rsp_t   exp_q[$];
    setup_t setup_q[$];
    int     slv_waits[$];
    logic [31:0] slv_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    int     psel_cycles, acc_cycles, psel_falls, stab_errs;
    setup_t cur_setup;
    logic   psel_prev = 1'b0;

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Bus monitor; cycle numbers follow "cycle k+1 follows edge k".
    always @(negedge PCLK) begin
        rsp_t r;
        if (bus.rsp_valid) begin
            r.err = bus.rsp_err; r.rdata = bus.rsp_rdata; r.cycle = cyc + 1;
            rsp_q.push_back(r);
        end
        if (bus.M_PSEL) psel_cycles++;
        if (bus.M_PSEL && !bus.M_PENABLE) begin
            cur_setup.wr = bus.M_PWRITE; cur_setup.addr = bus.M_PADDR; cur_setup.wdata = bus.M_PWDATA;
            setup_q.push_back(cur_setup);
        end
        if (bus.M_PSEL && bus.M_PENABLE) begin
            acc_cycles++;
            if (bus.M_PADDR !== cur_setup.addr || bus.M_PWRITE !== cur_setup.wr || bus.M_PWDATA !== cur_setup.wdata)
                stab_errs++;
        end
        if (psel_prev && !bus.M_PSEL) psel_falls++;
        psel_prev = bus.M_PSEL;
    end

    // APB slave: ready after the transfer's programmed number of wait states.
    int   cur_wait = 0;
    int   acc_n = 0;
    logic rdy;
    always begin
        @(posedge PCLK);
        #1;
        if (PRESETn && bus.M_PSEL && !bus.M_PENABLE) begin
            if (slv_waits.size() != 0) cur_wait = slv_waits.pop_front();
            else cur_wait = 0;
            acc_n = 0;
        end
        if (PRESETn && bus.M_PSEL && bus.M_PENABLE) begin
            rdy = (acc_n >= cur_wait);
            acc_n++;
            bus.M_PREADY = rdy;
            if (rdy && !bus.M_PWRITE)
                bus.M_PRDATA = slv_mem.exists(bus.M_PADDR) ? slv_mem[bus.M_PADDR] : dflt(bus.M_PADDR);
            else
                bus.M_PRDATA = $urandom;
            if (rdy && bus.M_PWRITE) slv_mem[bus.M_PADDR] = bus.M_PWDATA;
        end else begin
            bus.M_PREADY = 1'($urandom_range(0, 1));
            bus.M_PRDATA = $urandom;
        end
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        slv_mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic clear_mon();
        psel_cycles = 0; acc_cycles = 0; psel_falls = 0; stab_errs = 0;
        setup_q.delete(); rsp_q.delete(); exp_q.delete();
    endtask

    // Present one request (w = slave wait states), wait for acceptance, predict its response.
    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d, input int w);
        bit   got = 0;
        int   k;
        rsp_t e;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d;
        if (a[1:0] == 2'b00) slv_waits.push_back(w);
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge PCLK);
            if (bus.req_ready) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept addr=%h req_ready got 0 expected 1 within 100 cycles", a);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge PCLK);
        #1;
        k = cyc;
        e.rdata = '0;
        if (a[1:0] != 2'b00) begin
            e.err = 1'b1; e.cycle = k + 2;
        end else if (w >= int'(T)) begin
            e.err = 1'b1; e.cycle = k + int'(T) + 2;
        end else begin
            e.err = 1'b0; e.cycle = k + 3 + w;
            if (wr) ref_mem[a] = d;
            else e.rdata = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        end
        exp_q.push_back(e);
    endtask

    task automatic req_idle();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 400 && rsp_q.size() < exp_q.size(); i++) @(negedge PCLK);
        repeat (4) @(negedge PCLK);
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.M_PREADY = 1'b0; bus.M_PRDATA = '0;
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({bus.M_PSEL, bus.M_PENABLE, bus.M_PWRITE, bus.rsp_valid, bus.rsp_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl psel/penable/pwrite/rsp_valid/rsp_err got %b expected 00000",
                     {bus.M_PSEL, bus.M_PENABLE, bus.M_PWRITE, bus.rsp_valid, bus.rsp_err});
        end
        checks++;
        if (bus.M_PADDR !== 32'h0 || bus.M_PWDATA !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data paddr=%h pwdata=%h rdata=%h expected all 0", bus.M_PADDR, bus.M_PWDATA, bus.rsp_rdata);
        end
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;
        @(negedge PCLK);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle req_ready got %b expected 1", bus.req_ready);
        end
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_read_basic();
        rsp_t r, e;
        clear_mon();
        preload(SWITCH_ADDR, 32'hA5A5_0001);
        do_req(1'b0, SWITCH_ADDR, 32'h0, 0);
        req_idle();
        wait_rsp();
        checks++;
        if (psel_cycles != 2 || acc_cycles != 1) begin
            errors++;
            $display("FAIL read_basic psel_cycles=%0d penable_cycles=%0d expected 2 and 1", psel_cycles, acc_cycles);
        end
        checks++;
        if (setup_q.size() != 1 || setup_q[0].addr !== SWITCH_ADDR || setup_q[0].wr !== 1'b0) begin
            errors++;
            $display("FAIL read_basic setup count=%0d expected one read of %h", setup_q.size(), SWITCH_ADDR);
        end
        checks++;
        if (rsp_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL read_basic rsp_count got %0d expected %0d", rsp_q.size(), exp_q.size());
        end
        while (rsp_q.size() > 0 && exp_q.size() > 0) begin
            r = rsp_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (r.err !== e.err || r.rdata !== e.rdata || r.cycle != e.cycle) begin
                errors++;
                $display("FAIL read_basic rsp got err=%0b rdata=%h cycle=%0d expected err=%0b rdata=%h cycle=%0d",
                         r.err, r.rdata, r.cycle, e.err, e.rdata, e.cycle);
            end
        end
    endtask

    task automatic test_write_waits();
        rsp_t r, e;
        clear_mon();
        do_req(1'b1, 32'h0000_3004, 32'hDEAD_BEEF, 3);
        req_idle();
        wait_rsp();
        checks++;
        if (acc_cycles != 4 || stab_errs != 0) begin
            errors++;
            $display("FAIL write_waits access_cycles=%0d unstable=%0d expected 4 and 0", acc_cycles, stab_errs);
        end
        checks++;
        if (setup_q.size() != 1 || setup_q[0].addr !== 32'h3004 || setup_q[0].wdata !== 32'hDEAD_BEEF || setup_q[0].wr !== 1'b1) begin
            errors++;
            $display("FAIL write_waits setup count=%0d expected one write of DEADBEEF to 3004", setup_q.size());
        end
        do_req(1'b0, 32'h0000_3004, 32'h0, 0);
        req_idle();
        wait_rsp();
        checks++;
        if (rsp_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL write_waits rsp_count got %0d expected %0d", rsp_q.size(), exp_q.size());
        end
        while (rsp_q.size() > 0 && exp_q.size() > 0) begin
            r = rsp_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (r.err !== e.err || r.rdata !== e.rdata || r.cycle != e.cycle) begin
                errors++;
                $display("FAIL write_waits rsp got err=%0b rdata=%h cycle=%0d expected err=%0b rdata=%h cycle=%0d",
                         r.err, r.rdata, r.cycle, e.err, e.rdata, e.cycle);
            end
        end
    endtask

    task automatic test_back_to_back();
        rsp_t r, e;
        int   first, last;
        clear_mon();
        for (int unsigned i = 0; i < 4; i++) do_req(1'b0, TIMER_BASE + 32'(4 * i), 32'h0, 0);
        req_idle();
        wait_rsp();
        checks++;
        if (psel_falls != 1 || psel_cycles != 8) begin
            errors++;
            $display("FAIL back_to_back psel_falls=%0d psel_cycles=%0d expected 1 and 8", psel_falls, psel_cycles);
        end
        checks++;
        if (rsp_q.size() != 4) begin
            errors++;
            $display("FAIL back_to_back rsp_count got %0d expected 4", rsp_q.size());
        end else begin
            first = rsp_q[0].cycle; last = rsp_q[3].cycle;
            checks++;
            if (last - first != 6) begin
                errors++;
                $display("FAIL back_to_back rsp_span got %0d cycles expected 6", last - first);
            end
        end
        while (rsp_q.size() > 0 && exp_q.size() > 0) begin
            r = rsp_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (r.err !== e.err || r.rdata !== e.rdata || r.cycle != e.cycle) begin
                errors++;
                $display("FAIL back_to_back rsp got err=%0b rdata=%h cycle=%0d expected err=%0b rdata=%h cycle=%0d",
                         r.err, r.rdata, r.cycle, e.err, e.rdata, e.cycle);
            end
        end
    endtask

    task automatic test_misaligned();
        rsp_t r, e;
        clear_mon();
        do_req(1'b0, 32'h0000_3002, 32'h0, 0);
        do_req(1'b0, 32'h0000_3000, 32'h0, 1);
        req_idle();
        wait_rsp();
        checks++;
        if (psel_cycles != 3 || setup_q.size() != 1 || setup_q[0].addr !== 32'h3000) begin
            errors++;
            $display("FAIL misaligned psel_cycles=%0d setups=%0d expected 3 and 1 (addr 3000)", psel_cycles, setup_q.size());
        end
        checks++;
        if (rsp_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL misaligned rsp_count got %0d expected %0d", rsp_q.size(), exp_q.size());
        end
        while (rsp_q.size() > 0 && exp_q.size() > 0) begin
            r = rsp_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (r.err !== e.err || r.rdata !== e.rdata || r.cycle != e.cycle) begin
                errors++;
                $display("FAIL misaligned rsp got err=%0b rdata=%h cycle=%0d expected err=%0b rdata=%h cycle=%0d",
                         r.err, r.rdata, r.cycle, e.err, e.rdata, e.cycle);
            end
        end
    endtask

    task automatic test_timeout();
        rsp_t r, e;
        clear_mon();
        do_req(1'b0, 32'h0000_3010, 32'h0, 1000);
        req_idle();
        wait_rsp();
        checks++;
        if (acc_cycles != int'(T) || psel_falls != 1 || bus.M_PSEL !== 1'b0) begin
            errors++;
            $display("FAIL timeout_stuck access_cycles=%0d psel_falls=%0d psel=%b expected %0d 1 0", acc_cycles, psel_falls, bus.M_PSEL, T);
        end
        acc_cycles = 0;
        do_req(1'b0, 32'h0000_3014, 32'h0, int'(T) - 1);
        req_idle();
        wait_rsp();
        checks++;
        if (acc_cycles != int'(T)) begin
            errors++;
            $display("FAIL timeout_last access_cycles=%0d expected %0d", acc_cycles, T);
        end
        checks++;
        if (rsp_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL timeout rsp_count got %0d expected %0d", rsp_q.size(), exp_q.size());
        end
        while (rsp_q.size() > 0 && exp_q.size() > 0) begin
            r = rsp_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (r.err !== e.err || r.rdata !== e.rdata || r.cycle != e.cycle) begin
                errors++;
                $display("FAIL timeout rsp got err=%0b rdata=%h cycle=%0d expected err=%0b rdata=%h cycle=%0d",
                         r.err, r.rdata, r.cycle, e.err, e.rdata, e.cycle);
            end
        end
    endtask

    task automatic test_reset_mid();
        rsp_t        r, e;
        logic [31:0] wd;
        clear_mon();
        do_req(1'b0, 32'h0000_3020, 32'h1234_5678, 1000);
        req_idle();
        for (int i = 0; i < 20 && acc_cycles < 2; i++) @(negedge PCLK);
        checks++;
        if (acc_cycles < 2) begin
            errors++;
            $display("FAIL reset_mid access_cycles got %0d expected >= 2 before reset", acc_cycles);
        end
        exp_q.delete();
        #2;
        PRESETn = 1'b0;
        #1;
        checks++;
        if ({bus.M_PSEL, bus.M_PENABLE, bus.M_PWRITE, bus.rsp_valid} !== 4'b0 || bus.M_PADDR !== 32'h0 || bus.M_PWDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid async psel=%b penable=%b paddr=%h pwdata=%h rsp_valid=%b expected all 0",
                     bus.M_PSEL, bus.M_PENABLE, bus.M_PADDR, bus.M_PWDATA, bus.rsp_valid);
        end
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (5) @(posedge PCLK);
        #1;
        checks++;
        if (rsp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid abandoned rsp_count got %0d expected 0", rsp_q.size());
        end
        clear_mon();
        wd = $urandom;
        do_req(1'b1, LED_ADDR, wd, 1);
        do_req(1'b0, LED_ADDR, 32'h0, 0);
        req_idle();
        wait_rsp();
        checks++;
        if (rsp_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_mid rsp_count got %0d expected %0d", rsp_q.size(), exp_q.size());
        end
        while (rsp_q.size() > 0 && exp_q.size() > 0) begin
            r = rsp_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (r.err !== e.err || r.rdata !== e.rdata || r.cycle != e.cycle) begin
                errors++;
                $display("FAIL reset_mid rsp got err=%0b rdata=%h cycle=%0d expected err=%0b rdata=%h cycle=%0d",
                         r.err, r.rdata, r.cycle, e.err, e.rdata, e.cycle);
            end
        end
    endtask

    task automatic test_random();
        rsp_t        r, e;
        logic [31:0] a;
        int          n_aligned = 0;
        clear_mon();
        for (int i = 0; i < 40; i++) begin
            a = DMEM_BASE + 32'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            if (a[1:0] == 2'b00) n_aligned++;
            do_req(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 5)));
            if ($urandom_range(0, 1) == 1) begin
                req_idle();
                repeat ($urandom_range(0, 2)) begin
                    @(posedge PCLK);
                    #1;
                end
            end
        end
        req_idle();
        wait_rsp();
        checks++;
        if (stab_errs != 0 || setup_q.size() != n_aligned) begin
            errors++;
            $display("FAIL random unstable=%0d setups=%0d expected 0 and %0d", stab_errs, setup_q.size(), n_aligned);
        end
        checks++;
        if (rsp_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random rsp_count got %0d expected %0d", rsp_q.size(), exp_q.size());
        end
        while (rsp_q.size() > 0 && exp_q.size() > 0) begin
            r = rsp_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (r.err !== e.err || r.rdata !== e.rdata || r.cycle != e.cycle) begin
                errors++;
                $display("FAIL random rsp got err=%0b rdata=%h cycle=%0d expected err=%0b rdata=%h cycle=%0d",
                         r.err, r.rdata, r.cycle, e.err, e.rdata, e.cycle);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_basic();
        test_write_waits();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Turns single-beat CPU load/store requests (valid/ready request, one-cycle response pulse) into APB3 transfers.
- Drives the master side of the APB address-decode mux that fans out to data memory, switch, LED and timer.
- Owns the SETUP/ACCESS sequencing, PREADY wait states, a bounded-wait timeout and misaligned-address rejection.
- Supports back-to-back transfers without returning to IDLE.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before forced error termination; 0 disables the timeout.

Ports:
- PCLK  in  1  APB clock; sole clock.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  bridge accepts request this cycle (combinational from state and M_PREADY).
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid: misaligned or timeout.
- M_PADDR  out  ADDR_W  APB address.
- M_PWRITE  out  1  APB direction.
- M_PSEL  out  1  APB select.
- M_PENABLE  out  1  APB enable.
- M_PWDATA  out  DATA_W  APB write data.
- M_PRDATA  in  DATA_W  APB read data.
- M_PREADY  in  1  APB ready.

Behaviour:
- Clocking and reset: one clock, PCLK. PRESETn is asynchronous, active-low.
- Reset values:
  - State = IDLE.
  - M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA = 0.
  - rsp_valid, rsp_err, rsp_rdata = 0.
  - Timeout counter = 0.
- Reset mid-transfer: the transfer is abandoned silently; no response is ever issued for it.
- FSM states: IDLE, SETUP, ACCESS, ERR.
- Handshake: a request is accepted on a rising edge where req_valid && req_ready.
  - req_ready = (IDLE) || (ACCESS && transfer completing this cycle).
  - req_ready = 0 in SETUP and ERR.
  - req_* must be held stable by the CPU until accepted.
- Misalignment check: at accept, req_addr[1:0] != 0 means misaligned → next state ERR. No APB activity occurs for that request.
- Aligned accept → next state SETUP:
  - Register M_PADDR, M_PWRITE, M_PWDATA.
  - M_PSEL = 1, M_PENABLE = 0.
- SETUP → ACCESS unconditionally: M_PENABLE = 1; timeout counter cleared.
- ACCESS completes when M_PREADY = 1 on the edge:
  - Registered rsp_valid = 1 next cycle, rsp_err = 0.
  - rsp_rdata = M_PRDATA for reads, 0 for writes.
  - M_PENABLE = 0 next cycle.
  - If a new aligned request is accepted on the same edge → SETUP (M_PSEL stays 1).
  - If the new request is misaligned → ERR with M_PSEL = 0.
  - Otherwise → IDLE with M_PSEL = 0.
- Timeout (only when TIMEOUT_CYCLES != 0):
  - The counter increments each ACCESS cycle without M_PREADY.
  - When the counter == TIMEOUT_CYCLES-1 and M_PREADY = 0, the transfer is terminated as completing: rsp_err = 1, rsp_rdata = 0.
  - M_PREADY on that same cycle wins; response is normal.
  - ACCESS therefore lasts at most TIMEOUT_CYCLES cycles.
- ERR state:
  - Lasts one cycle with M_PSEL = 0.
  - Produces rsp_valid = 1, rsp_err = 1, rsp_rdata = 0 on the following cycle.
  - Then → IDLE.
- Latency (accept at edge k): SETUP in k+1, ACCESS in k+2, rsp_valid in cycle k+3 with zero wait states. Each wait state adds 1 cycle. Misaligned request: rsp_valid in cycle k+2.
- Steady-state throughput: one transfer per 2 cycles with zero wait states.
- Output holding: M_PADDR, M_PWRITE and M_PWDATA hold their last values in IDLE and ERR. rsp_valid is never high for 2 consecutive cycles from the same transfer.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.

Decomposition:
- Shared package apb_pkg:
  - apb_state_e enum {IDLE, SETUP, ACCESS, ERR}.
  - APB_ADDR_W and APB_DATA_W constants.
  - Peripheral base addresses: DMEM 0x3000–0x37FF, SWITCH 0x20, LED 0x24, TIMER 0x00–0x18.
- Single module; the timeout counter stays inline. No sub-module is needed.

Test Plan:
- Aligned read 0x20, M_PREADY tied 1, M_PRDATA=0xA5A5_0001 → PSEL high 2 cycles, PENABLE in the 2nd; rsp_valid at k+3 with rdata 0xA5A5_0001, err 0.
- Write 0x3004 data 0xDEAD_BEEF, M_PREADY low for 3 ACCESS cycles → PADDR/PWDATA/PWRITE stable throughout; rsp_valid at k+6, err 0, rdata 0.
- Back-to-back: req_valid held high with 4 aligned reads 0x0, 0x4, 0x8, 0xC, M_PREADY = 1 → PSEL never drops; 4 rsp pulses spaced 2 cycles apart, data in order.
- Misaligned load 0x3002 → no PSEL assertion; rsp_valid at k+2 with err 1, rdata 0; a following aligned request completes normally.
- TIMEOUT_CYCLES=4, M_PREADY stuck 0 → ACCESS exactly 4 cycles, then PSEL=0 and rsp err 1. Repeat with M_PREADY=1 on the 4th ACCESS cycle → err 0.
- PRESETn pulsed low during ACCESS → all APB outputs 0 asynchronously, no rsp_valid; the next request after release completes normally.
